acc_cpu_core: RTL and testbench

Parametrised multi-cycle accumulator CPU core; next generation of the fixed 16-bit/8-bit-address accumulator CPU top.
Contains PC, IR, MAR, MBR, BR, ACC, flags and a hardwired FSM control unit in one block.

---
 rtl/acc_cpu_core.sv | 224 ++++++++++++++++++++++
 tb/tb_acc_cpu_core.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU core with parametrised widths, a req/ready memory
// handshake with wait states, full {Z,C,V,N} flags and halted/illegal status.
module acc_cpu_core #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [DATA_W-1:0] acc,
   output logic [ADDR_W-1:0] pc,
   output logic [3:0]        flags,
   output logic              halted,
   output logic              illegal
);

   localparam int SH_W = $clog2(DATA_W);

   localparam logic [7:0] OP_STORE  = 8'h01;
   localparam logic [7:0] OP_LOAD   = 8'h02;
   localparam logic [7:0] OP_ADD    = 8'h03;
   localparam logic [7:0] OP_SUB    = 8'h04;
   localparam logic [7:0] OP_JMPGEZ = 8'h05;
   localparam logic [7:0] OP_JMP    = 8'h06;
   localparam logic [7:0] OP_HALT   = 8'h07;
   localparam logic [7:0] OP_MPY    = 8'h08;
   localparam logic [7:0] OP_AND    = 8'h0A;
   localparam logic [7:0] OP_OR     = 8'h0B;
   localparam logic [7:0] OP_NOT    = 8'h0C;
   localparam logic [7:0] OP_SHR    = 8'h0D;
   localparam logic [7:0] OP_SHL    = 8'h0E;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      READ,
      EXEC,
      WRITE,
      HALT
   } state_t;

   state_t              state;
   logic [DATA_W-1:0]   ir;
   logic [DATA_W-1:0]   br;
   logic [7:0]          ir_op;
   logic [ADDR_W-1:0]   ir_addr;
   logic                ir_unused;

   logic [DATA_W:0]     sum;
   logic [DATA_W:0]     diff;
   logic [2*DATA_W-1:0] prod;
   logic [SH_W-1:0]     sh;
   logic [DATA_W:0]     shr_t;
   logic [DATA_W:0]     shl_t;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_c;
   logic                alu_v;

   assign ir_op     = ir[DATA_W-1 -: 8];
   assign ir_addr   = ir[ADDR_W-1:0];
   assign ir_unused = ^ir;

   // Shifts carry one guard bit so the last bit shifted out lands in a fixed position.
   assign sum   = {1'b0, acc} + {1'b0, br};
   assign diff  = {1'b0, acc} - {1'b0, br};
   assign prod  = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, br};
   assign sh    = br[SH_W-1:0];
   assign shr_t = {acc, 1'b0} >> sh;
   assign shl_t = {1'b0, acc} << sh;

   always_comb begin
      alu_res = acc;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (ir_op)
         OP_LOAD: alu_res = br;
         OP_ADD: begin
            alu_res = sum[DATA_W-1:0];
            alu_c   = sum[DATA_W];
            alu_v   = (acc[DATA_W-1] == br[DATA_W-1]) && (sum[DATA_W-1] != acc[DATA_W-1]);
         end
         OP_SUB: begin
            alu_res = diff[DATA_W-1:0];
            alu_c   = diff[DATA_W];
            alu_v   = (acc[DATA_W-1] != br[DATA_W-1]) && (diff[DATA_W-1] != acc[DATA_W-1]);
         end
         OP_MPY: begin
            alu_res = prod[DATA_W-1:0];
            alu_c   = |prod[2*DATA_W-1:DATA_W];
         end
         OP_AND: alu_res = acc & br;
         OP_OR:  alu_res = acc | br;
         OP_SHR: begin
            alu_res = shr_t[DATA_W:1];
            alu_c   = shr_t[0];
         end
         OP_SHL: begin
            alu_res = shl_t[DATA_W-1:0];
            alu_c   = shl_t[DATA_W];
         end
         default: alu_res = acc;
      endcase
   end

   // Memory outputs are set up on entry to an access state and held until mem_ready,
   // so a wait state never disturbs them; after reset FETCH spends one cycle raising mem_req.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         acc       <= '0;
         flags     <= '0;
         ir        <= '0;
         br        <= '0;
         halted    <= 1'b0;
         illegal   <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= RESET_PC;
         mem_wdata <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
               end else if (mem_ready) begin
                  ir      <= mem_rdata;
                  pc      <= pc + ADDR_W'(1);
                  mem_req <= 1'b0;
                  state   <= DECODE;
               end
            end
            DECODE: begin
               case (ir_op)
                  OP_LOAD, OP_ADD, OP_SUB, OP_MPY, OP_AND, OP_OR, OP_SHR, OP_SHL: begin
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= ir_addr;
                     state    <= READ;
                  end
                  OP_STORE: begin
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b1;
                     mem_addr  <= ir_addr;
                     mem_wdata <= acc;
                     state     <= WRITE;
                  end
                  OP_JMP: begin
                     pc       <= ir_addr;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= ir_addr;
                     state    <= FETCH;
                  end
                  OP_JMPGEZ: begin
                     if (!acc[DATA_W-1]) begin
                        pc       <= ir_addr;
                        mem_addr <= ir_addr;
                     end else begin
                        mem_addr <= pc;
                     end
                     mem_req <= 1'b1;
                     mem_we  <= 1'b0;
                     state   <= FETCH;
                  end
                  OP_NOT: begin
                     acc      <= ~acc;
                     flags    <= {&acc, 1'b0, 1'b0, ~acc[DATA_W-1]};
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= pc;
                     state    <= FETCH;
                  end
                  OP_HALT: begin
                     halted <= 1'b1;
                     state  <= HALT;
                  end
                  default: begin
                     illegal <= 1'b1;
                     halted  <= 1'b1;
                     state   <= HALT;
                  end
               endcase
            end
            READ: begin
               if (mem_ready) begin
                  br      <= mem_rdata;
                  mem_req <= 1'b0;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               acc      <= alu_res;
               flags    <= {alu_res == '0, alu_c, alu_v, alu_res[DATA_W-1]};
               mem_req  <= 1'b1;
               mem_we   <= 1'b0;
               mem_addr <= pc;
               state    <= FETCH;
            end
            WRITE: begin
               if (mem_ready) begin
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
                  state    <= FETCH;
               end
            end
            HALT: begin
               mem_req <= 1'b0;
               halted  <= 1'b1;
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core: memory model with wait states, a write
// scoreboard and an expected-end-state scoreboard consumed when the core halts.
module tb_acc_cpu_core;

   localparam int DW = 16;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic [DW-1:0] acc;
   logic [AW-1:0] pc;
   logic [3:0]    flags;
   logic          halted;
   logic          illegal;

   acc_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(8'h00)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .acc       (acc),
      .pc        (pc),
      .flags     (flags),
      .halted    (halted),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      logic [15:0] acc;
      logic [3:0]  flags;
      logic [7:0]  pc;
      logic        ill;
      int          cycles;
   } end_t;

   logic [DW-1:0] mem [0:255];
   wr_t           wr_q[$];
   end_t          end_q[$];
   int            waits = 0;
   bit            stall_writes = 1'b0;
   int            wait_cnt = 0;
   logic [AW-1:0] hold_addr;
   logic          hold_we;
   logic [DW-1:0] hold_wdata;
   int            vectors = 0;
   int            miscompares = 0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ins(input logic [7:0] op, input logic [7:0] a);
      return {op, a};
   endfunction

   task automatic clearMem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
   endtask

   task automatic applyStimulus(input int a, input logic [15:0] d);
      mem[a] = d;
   endtask

   task automatic expectWrite(input logic [7:0] a, input logic [15:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      wr_q.push_back(w);
   endtask

   task automatic expectEnd(input logic [15:0] a, input logic [3:0] f, input logic [7:0] p,
                            input logic il, input int cyc);
      end_t e;
      e.acc    = a;
      e.flags  = f;
      e.pc     = p;
      e.ill    = il;
      e.cycles = cyc;
      end_q.push_back(e);
   endtask

   // Memory responder: decides mem_ready just after each falling edge, so the
   // handshake completes on the following rising edge unless reset intervenes.
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         #1;
         if (mem_req && !rst && !(stall_writes && mem_we) && wait_cnt >= waits) begin
            mem_ready = 1'b1;
            mem_rdata = mem[mem_addr];
            if (mem_we) begin
               mem[mem_addr] = mem_wdata;
               checkOutput("write_expected", 32'(wr_q.size() > 0), 32'd1);
               if (wr_q.size() > 0) begin
                  wr_t w;
                  w = wr_q.pop_front();
                  checkOutput("write_addr", 32'(mem_addr), 32'(w.addr));
                  checkOutput("write_data", 32'(mem_wdata), 32'(w.data));
               end
            end
            wait_cnt = 0;
         end else begin
            mem_ready = 1'b0;
            if (mem_req) begin
               if (wait_cnt == 0) begin
                  hold_addr  = mem_addr;
                  hold_we    = mem_we;
                  hold_wdata = mem_wdata;
               end else begin
                  checkOutput("hold_addr", 32'(mem_addr), 32'(hold_addr));
                  checkOutput("hold_we", 32'(mem_we), 32'(hold_we));
                  checkOutput("hold_wdata", 32'(mem_wdata), 32'(hold_wdata));
               end
               wait_cnt++;
            end else begin
               wait_cnt = 0;
            end
         end
      end
   end

   task automatic applyReset(input string name);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput({name, "_rst_req"}, 32'(mem_req), 32'd0);
      checkOutput({name, "_rst_pc"}, 32'(pc), 32'h00);
      checkOutput({name, "_rst_acc"}, 32'(acc), 32'h0000);
      checkOutput({name, "_rst_flags"}, 32'(flags), 32'h0);
      checkOutput({name, "_rst_halted"}, 32'(halted), 32'd0);
      checkOutput({name, "_rst_illegal"}, 32'(illegal), 32'd0);
      rst = 1'b0;
   endtask

   // The first rising edge with rst low is the release edge; cycles are counted from it.
   task automatic runUntilHalt(input string name, input int limit);
      int   cyc;
      end_t e;
      cyc = 0;
      while (!halted && cyc < limit) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput({name, "_halted"}, 32'(halted), 32'd1);
      e = end_q.pop_front();
      checkOutput({name, "_acc"}, 32'(acc), 32'(e.acc));
      checkOutput({name, "_flags"}, 32'(flags), 32'(e.flags));
      checkOutput({name, "_pc"}, 32'(pc), 32'(e.pc));
      checkOutput({name, "_illegal"}, 32'(illegal), 32'(e.ill));
      if (e.cycles >= 0) checkOutput({name, "_cycles"}, 32'(cyc - 1), 32'(e.cycles));
      @(negedge clk);
      checkOutput({name, "_halt_req"}, 32'(mem_req), 32'd0);
      checkOutput({name, "_writes_left"}, 32'(wr_q.size()), 32'd0);
   endtask

   task automatic loadBasic();
      clearMem();
      applyStimulus(8'h00, 16'h0210);
      applyStimulus(8'h01, 16'h0311);
      applyStimulus(8'h02, 16'h0112);
      applyStimulus(8'h03, 16'h0700);
      applyStimulus(8'h10, 16'h0005);
      applyStimulus(8'h11, 16'h0003);
   endtask

   task automatic loadData();
      clearMem();
      applyStimulus(8'h10, 16'h7FFF);
      applyStimulus(8'h11, 16'h0001);
      applyStimulus(8'h12, 16'h8000);
      applyStimulus(8'h13, 16'h0100);
      applyStimulus(8'h14, 16'h0000);
      applyStimulus(8'h15, 16'h8001);
      applyStimulus(8'h16, 16'h0002);
      applyStimulus(8'h17, 16'h0010);
      applyStimulus(8'h18, 16'h0F0F);
      applyStimulus(8'h19, 16'hF000);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;

      // Basic program, zero-wait memory
      waits = 0;
      loadBasic();
      expectWrite(8'h12, 16'h0008);
      expectEnd(16'h0008, 4'b0000, 8'h04, 1'b0, 13);
      applyReset("basic");
      runUntilHalt("basic", 200);
      checkOutput("basic_mem12", 32'(mem[8'h12]), 32'h0008);

      // Same program with three wait states per access
      waits = 3;
      loadBasic();
      expectWrite(8'h12, 16'h0008);
      expectEnd(16'h0008, 4'b0000, 8'h04, 1'b0, 34);
      applyReset("waits");
      runUntilHalt("waits", 400);
      checkOutput("waits_mem12", 32'(mem[8'h12]), 32'h0008);
      waits = 0;

      // Signed overflow on ADD
      loadData();
      applyStimulus(0, ins(8'h02, 8'h10));
      applyStimulus(1, ins(8'h03, 8'h11));
      applyStimulus(2, ins(8'h07, 8'h00));
      expectEnd(16'h8000, 4'b0011, 8'h03, 1'b0, 10);
      applyReset("add_ovf");
      runUntilHalt("add_ovf", 200);

      // SUB to zero
      loadData();
      applyStimulus(0, ins(8'h02, 8'h10));
      applyStimulus(1, ins(8'h03, 8'h11));
      applyStimulus(2, ins(8'h04, 8'h12));
      applyStimulus(3, ins(8'h07, 8'h00));
      expectEnd(16'h0000, 4'b1000, 8'h04, 1'b0, 14);
      applyReset("sub_zero");
      runUntilHalt("sub_zero", 200);

      // MPY with nonzero high half
      loadData();
      applyStimulus(0, ins(8'h02, 8'h13));
      applyStimulus(1, ins(8'h08, 8'h13));
      applyStimulus(2, ins(8'h07, 8'h00));
      expectEnd(16'h0000, 4'b1100, 8'h03, 1'b0, 10);
      applyReset("mpy");
      runUntilHalt("mpy", 200);

      // SUB borrow: 0 - 1
      loadData();
      applyStimulus(0, ins(8'h02, 8'h14));
      applyStimulus(1, ins(8'h04, 8'h11));
      applyStimulus(2, ins(8'h07, 8'h00));
      expectEnd(16'hFFFF, 4'b0101, 8'h03, 1'b0, 10);
      applyReset("borrow");
      runUntilHalt("borrow", 200);

      // SHR by 1 then SHL by 2 shifting the only set bit out
      loadData();
      applyStimulus(0, ins(8'h02, 8'h15));
      applyStimulus(1, ins(8'h0D, 8'h11));
      applyStimulus(2, ins(8'h0E, 8'h16));
      applyStimulus(3, ins(8'h07, 8'h00));
      expectEnd(16'h0000, 4'b1100, 8'h04, 1'b0, 14);
      applyReset("shifts");
      runUntilHalt("shifts", 200);

      // Shift amount field of zero (upper operand bits ignored)
      loadData();
      applyStimulus(0, ins(8'h02, 8'h15));
      applyStimulus(1, ins(8'h0D, 8'h17));
      applyStimulus(2, ins(8'h07, 8'h00));
      expectEnd(16'h8001, 4'b0001, 8'h03, 1'b0, 10);
      applyReset("shr0");
      runUntilHalt("shr0", 200);

      // NOT, AND, OR then STORE
      loadData();
      applyStimulus(0, ins(8'h02, 8'h15));
      applyStimulus(1, ins(8'h0C, 8'h00));
      applyStimulus(2, ins(8'h0A, 8'h18));
      applyStimulus(3, ins(8'h0B, 8'h19));
      applyStimulus(4, ins(8'h01, 8'h1A));
      applyStimulus(5, ins(8'h07, 8'h00));
      expectWrite(8'h1A, 16'hFF0E);
      expectEnd(16'hFF0E, 4'b0001, 8'h06, 1'b0, 4 + 2 + 4 + 4 + 3 + 2);
      applyReset("logic");
      runUntilHalt("logic", 200);

      // NOT of zero
      loadData();
      applyStimulus(0, ins(8'h02, 8'h14));
      applyStimulus(1, ins(8'h0C, 8'h00));
      applyStimulus(2, ins(8'h07, 8'h00));
      expectEnd(16'hFFFF, 4'b0001, 8'h03, 1'b0, 8);
      applyReset("not");
      runUntilHalt("not", 200);

      // Branches: JMPGEZ not taken on negative, taken on positive, JMP to 0xFF and wrap
      clearMem();
      applyStimulus(8'h00, ins(8'h02, 8'h30));
      applyStimulus(8'h01, ins(8'h05, 8'h20));
      applyStimulus(8'h02, ins(8'h02, 8'h31));
      applyStimulus(8'h03, ins(8'h05, 8'h20));
      applyStimulus(8'h04, ins(8'h07, 8'h00));
      applyStimulus(8'h20, ins(8'h01, 8'h00));
      applyStimulus(8'h21, ins(8'h06, 8'hFF));
      applyStimulus(8'hFF, ins(8'h01, 8'h34));
      applyStimulus(8'h30, 16'h8000);
      applyStimulus(8'h31, 16'h0700);
      expectWrite(8'h00, 16'h0700);
      expectWrite(8'h34, 16'h0700);
      expectEnd(16'h0700, 4'b0000, 8'h01, 1'b0, 4 + 2 + 4 + 2 + 3 + 2 + 3 + 2);
      applyReset("branch");
      runUntilHalt("branch", 300);

      // Illegal opcode at address 0
      clearMem();
      applyStimulus(8'h00, 16'hFF00);
      applyReset("illegal");
      @(negedge clk);
      checkOutput("ill_c1_req", 32'(mem_req), 32'd1);
      checkOutput("ill_c1_flag", 32'(illegal), 32'd0);
      @(negedge clk);
      checkOutput("ill_c2_flag", 32'(illegal), 32'd0);
      @(negedge clk);
      checkOutput("ill_c3_flag", 32'(illegal), 32'd1);
      checkOutput("ill_c3_halted", 32'(halted), 32'd1);
      checkOutput("ill_c3_pc", 32'(pc), 32'h01);
      for (int i = 0; i < 5; i++) begin
         checkOutput("ill_req_low", 32'(mem_req), 32'd0);
         checkOutput("ill_stays", 32'(illegal), 32'd1);
         @(negedge clk);
      end

      // Reset while a STORE is stalled waiting for mem_ready
      clearMem();
      applyStimulus(8'h00, ins(8'h02, 8'h10));
      applyStimulus(8'h01, ins(8'h01, 8'h12));
      applyStimulus(8'h02, ins(8'h07, 8'h00));
      applyStimulus(8'h10, 16'h1234);
      applyStimulus(8'h12, 16'hAAAA);
      stall_writes = 1'b1;
      expectWrite(8'h12, 16'h1234);
      applyReset("midrst");
      n = 0;
      while (!(mem_req && mem_we) && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("midrst_in_write", 32'(mem_req && mem_we), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_req", 32'(mem_req), 32'd0);
      checkOutput("midrst_pc", 32'(pc), 32'h00);
      checkOutput("midrst_acc", 32'(acc), 32'h0000);
      checkOutput("midrst_flags", 32'(flags), 32'h0);
      checkOutput("midrst_mem12", 32'(mem[8'h12]), 32'hAAAA);
      rst = 1'b0;
      stall_writes = 1'b0;
      @(negedge clk);
      checkOutput("midrst_refetch_req", 32'(mem_req), 32'd1);
      checkOutput("midrst_refetch_we", 32'(mem_we), 32'd0);
      checkOutput("midrst_refetch_addr", 32'(mem_addr), 32'h00);
      expectEnd(16'h1234, 4'b0000, 8'h03, 1'b0, -1);
      runUntilHalt("midrst", 200);
      checkOutput("midrst_mem12_final", 32'(mem[8'h12]), 32'h1234);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
